// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;
  localparam int          ENTRY_W         = 64;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {instruction, pc} entries.
// A push and a pop may share a cycle even when the queue is full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // When full, the write slot is the head being popped this cycle, so it is safe to overwrite.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= inc_ptr(r_wr_ptr);
      end
      if (w_pop_ok) r_rd_ptr <= inc_ptr(r_rd_ptr);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, fetch control FSM and decode-side handshake.
// Instruction memory is read combinationally at the current PC.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd4,
  parameter logic [31:0] PC_MAX   = 32'd56,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        done,
  output logic [15:0] fetch_count
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  logic         r_done;
  logic [15:0]  r_fetch_count;
  logic         w_pop;
  logic         w_fetch;
  logic         w_flush;
  logic         w_empty;
  logic         w_full;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head_entry;

  assign w_pop        = inst_valid & inst_ready;
  assign w_flush      = redirect_valid & (r_state != IDLE);
  assign w_fetch      = (r_state == FETCH) & run & ~redirect_valid &
                        (r_pc <= PC_MAX) & (~w_full | w_pop);
  assign w_push_entry = '{inst: imem_data, pc: r_pc};

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (w_flush),
    .i_push      (w_fetch),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head_entry),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign imem_addr   = r_pc;
  assign inst_valid  = ~w_empty;
  assign inst_data   = w_head_entry.inst;
  assign inst_pc     = w_head_entry.pc;
  assign done        = r_done;
  assign fetch_count = r_fetch_count;

  // A redirect outside IDLE overrides every other transition; in IDLE it only moves the PC.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    if (w_fetch) w_next_pc = r_pc + PC_STEP;
    case (r_state)
      IDLE: begin
        if (run) w_next_state = FETCH;
        if (redirect_valid) w_next_pc = align_pc(redirect_pc);
      end
      FETCH: begin
        if (r_pc > PC_MAX) w_next_state = DRAIN;
        else if (!run)     w_next_state = IDLE;
      end
      DRAIN: begin
        if (w_empty) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
    if (w_flush) begin
      w_next_pc    = align_pc(redirect_pc);
      w_next_state = run ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_done        <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_done  <= (w_next_state == DONE);
      if (w_pop && r_fetch_count != 16'hFFFF) r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scenarios for the fetch unit with a combinational instruction memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        done;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address so each word is distinct.
  assign imem_data = imem_addr ^ 32'hDEAD_BEEF;

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .done           (done),
    .fetch_count    (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    run            = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    run            = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b expected 0", inst_valid); end
    checks++; if (inst_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", inst_data); end
    checks++; if (inst_pc !== 32'd0) begin errors++; $display("[TB] FAIL rst_pc: got %0d expected 0", inst_pc); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b expected 0", done); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", fetch_count); end
    checks++; if (imem_addr !== 32'd4) begin errors++; $display("[TB] FAIL rst_addr: got %0d expected 4", imem_addr); end
    reset = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'd4) begin errors++; $display("[TB] FAIL idle_addr: got %0d expected 4", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %0b expected 0", inst_valid); end
  endtask

  task automatic test_sequence();
    int k = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    int wait_cyc = 0;
    apply_reset();
    run = 1'b1;
    inst_ready = 1'b1;
    while (k < 14 && cyc < 40) begin
      tick();
      cyc++;
      if (inst_valid) begin
        if (first < 0) first = cyc;
        checks++; if (inst_pc !== 32'(4 + 4 * k)) begin errors++; $display("[TB] FAIL seq_pc: got %0d expected %0d", inst_pc, 4 + 4 * k); end
        checks++; if (inst_data !== exp_inst(32'(4 + 4 * k))) begin errors++; $display("[TB] FAIL seq_data: got %h expected %h", inst_data, exp_inst(32'(4 + 4 * k))); end
        k++;
        last = cyc;
      end
    end
    checks++; if (k != 14) begin errors++; $display("[TB] FAIL seq_beats: got %0d expected 14", k); end
    checks++; if (first != 2) begin errors++; $display("[TB] FAIL seq_latency: got %0d expected 2", first); end
    checks++; if (last - first != 13) begin errors++; $display("[TB] FAIL seq_rate: got %0d expected 13", last - first); end
    while (!done && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    checks++; if (wait_cyc != 2) begin errors++; $display("[TB] FAIL seq_done_delay: got %0d expected 2", wait_cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL seq_done: got %0b expected 1", done); end
    checks++; if (fetch_count !== 16'd14) begin errors++; $display("[TB] FAIL seq_count: got %0d expected 14", fetch_count); end
    checks++; if (imem_addr !== 32'd60) begin errors++; $display("[TB] FAIL seq_final_addr: got %0d expected 60", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_drained: got %0b expected 0", inst_valid); end
  endtask

  task automatic test_stall();
    int cyc = 0;
    int k = 0;
    apply_reset();
    run = 1'b1;
    inst_ready = 1'b1;
    while (!(inst_valid && inst_pc == 32'd20) && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++; if (!(inst_valid && inst_pc == 32'd20)) begin errors++; $display("[TB] FAIL stall_reach: got %0d expected 20", inst_pc); end
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd20) begin errors++; $display("[TB] FAIL stall_hold_pc: got %0d expected 20", inst_pc); end
      checks++; if (inst_data !== exp_inst(32'd20)) begin errors++; $display("[TB] FAIL stall_hold_data: got %h expected %h", inst_data, exp_inst(32'd20)); end
    end
    checks++; if (imem_addr !== 32'd28) begin errors++; $display("[TB] FAIL stall_addr: got %0d expected 28", imem_addr); end
    inst_ready = 1'b1;
    cyc = 0;
    while (k < 6 && cyc < 12) begin
      tick();
      cyc++;
      if (inst_valid) begin
        checks++; if (inst_pc !== 32'(24 + 4 * k)) begin errors++; $display("[TB] FAIL stall_resume_pc: got %0d expected %0d", inst_pc, 24 + 4 * k); end
        k++;
      end
    end
    checks++; if (k != 6) begin errors++; $display("[TB] FAIL stall_resume_beats: got %0d expected 6", k); end
  endtask

  task automatic test_redirect_full();
    int cyc = 0;
    int k = 0;
    int first = -1;
    apply_reset();
    run = 1'b1;
    repeat (4) tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd4) begin errors++; $display("[TB] FAIL redir_full_head: got %0d expected 4", inst_pc); end
    checks++; if (imem_addr !== 32'd12) begin errors++; $display("[TB] FAIL redir_full_addr: got %0d expected 12", imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'd22;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %0b expected 0", inst_valid); end
    checks++; if (imem_addr !== 32'd20) begin errors++; $display("[TB] FAIL redir_target: got %0d expected 20", imem_addr); end
    inst_ready = 1'b1;
    while (k < 4 && cyc < 10) begin
      tick();
      cyc++;
      if (inst_valid) begin
        if (first < 0) first = cyc;
        checks++; if (inst_pc !== 32'(20 + 4 * k)) begin errors++; $display("[TB] FAIL redir_seq_pc: got %0d expected %0d", inst_pc, 20 + 4 * k); end
        k++;
      end
    end
    checks++; if (k != 4 || first != 1) begin errors++; $display("[TB] FAIL redir_seq_timing: got %0d beats first %0d expected 4 first 1", k, first); end
  endtask

  task automatic test_redirect_pop();
    int cyc = 0;
    apply_reset();
    run = 1'b1;
    inst_ready = 1'b1;
    while (!(inst_valid && inst_pc == 32'd12) && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++; if (!(inst_valid && inst_pc == 32'd12)) begin errors++; $display("[TB] FAIL rpop_reach: got %0d expected 12", inst_pc); end
    checks++; if (fetch_count !== 16'd2) begin errors++; $display("[TB] FAIL rpop_count_before: got %0d expected 2", fetch_count); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'd40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("[TB] FAIL rpop_count_after: got %0d expected 3", fetch_count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rpop_flush: got %0b expected 0", inst_valid); end
    inst_ready = 1'b0;
    cyc = 0;
    while (!inst_valid && cyc < 5) begin
      tick();
      cyc++;
    end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd40) begin errors++; $display("[TB] FAIL rpop_next_pc: got %0d expected 40", inst_pc); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("[TB] FAIL rpop_count_hold: got %0d expected 3", fetch_count); end
  endtask

  task automatic test_done_replay();
    int cyc = 0;
    int k = 0;
    apply_reset();
    run = 1'b1;
    inst_ready = 1'b1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL replay_done1: got %0b expected 1", done); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    tick();
    redirect_valid = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL replay_done_drop: got %0b expected 0", done); end
    cyc = 0;
    while (k < 14 && cyc < 40) begin
      tick();
      cyc++;
      if (inst_valid) begin
        checks++; if (inst_pc !== 32'(4 + 4 * k)) begin errors++; $display("[TB] FAIL replay_pc: got %0d expected %0d", inst_pc, 4 + 4 * k); end
        k++;
      end
    end
    checks++; if (k != 14) begin errors++; $display("[TB] FAIL replay_beats: got %0d expected 14", k); end
    cyc = 0;
    while (!done && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL replay_done2: got %0b expected 1", done); end
    checks++; if (fetch_count !== 16'd28) begin errors++; $display("[TB] FAIL replay_count: got %0d expected 28", fetch_count); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    run = 1'b1;
    inst_ready = 1'b1;
    repeat (5) tick();
    checks++; if (fetch_count !== 16'd3 || inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre: got count %0d valid %0b expected 3 1", fetch_count, inst_valid); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %0b expected 0", inst_valid); end
    checks++; if (inst_data !== 32'd0 || inst_pc !== 32'd0) begin errors++; $display("[TB] FAIL areset_head: got %h/%0d expected 0/0", inst_data, inst_pc); end
    checks++; if (done !== 1'b0 || fetch_count !== 16'd0) begin errors++; $display("[TB] FAIL areset_status: got %0b/%0d expected 0/0", done, fetch_count); end
    tick();
    reset = 1'b0;
    run = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'd4) begin errors++; $display("[TB] FAIL areset_pc: got %0d expected 4", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_after_valid: got %0b expected 0", inst_valid); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_done_replay();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
